// File: rtl/rom_bus_arbiter.sv
// rom_bus_arbiter: shares the single cart PSRAM port between the SNES bus,
// the MCU and the S-DD1 decompressor. Each access is run with fixed strobe
// timing. SNES always wins. MCU and S-DD1 share the remaining slots, and a
// streak counter keeps a busy S-DD1 from starving the MCU.
module rom_bus_arbiter #(
    parameter int ROM_CYCLES   = 5,
    parameter int WR_CYCLES    = 6,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        snes_req,
    input  logic        snes_we,
    input  logic [23:0] snes_addr,
    input  logic [7:0]  snes_wdata,
    output logic [7:0]  snes_rdata,
    output logic        snes_ack,
    input  logic        mcu_req,
    input  logic        mcu_we,
    input  logic [23:0] mcu_addr,
    input  logic [7:0]  mcu_wdata,
    output logic [7:0]  mcu_rdata,
    output logic        mcu_ack,
    input  logic        sdd1_req,
    input  logic [23:0] sdd1_addr,
    output logic [7:0]  sdd1_rdata,
    output logic        sdd1_ack,
    output logic [23:0] ROM_ADDR,
    input  logic [7:0]  ROM_DQ_I,
    output logic [7:0]  ROM_DQ_O,
    output logic        ROM_DQ_OE,
    output logic        ROM_OE_N,
    output logic        ROM_WE_N,
    output logic        busy
);

    localparam logic [7:0] RD_LAST    = 8'(ROM_CYCLES);
    localparam logic [7:0] WR_LAST    = 8'(WR_CYCLES);
    localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_WR_HOLD} state_t;
    typedef enum logic [1:0] {OWN_SNES, OWN_MCU, OWN_SDD1} owner_t;

    state_t      r_state;
    owner_t      r_owner;
    logic [7:0]  r_cnt;
    logic [3:0]  r_streak;

    logic        r_snesPend, r_snesWe;
    logic [23:0] r_snesAddr;
    logic [7:0]  r_snesWdata;
    logic        r_mcuPend, r_mcuWe;
    logic [23:0] r_mcuAddr;
    logic [7:0]  r_mcuWdata;
    logic        r_sdd1Pend;
    logic [23:0] r_sdd1Addr;

    logic [23:0] r_romAddr;
    logic [7:0]  r_romDqO;
    logic        r_romDqOe, r_romOeN, r_romWeN;
    logic        r_snesAck, r_mcuAck, r_sdd1Ack;
    logic [7:0]  r_snesRdata, r_mcuRdata, r_sdd1Rdata;

    logic        w_grantSnes, w_grantMcu, w_grantSdd1, w_anyGrant;
    owner_t      w_selOwner;
    logic        w_selWe;
    logic [23:0] w_selAddr;
    logic [7:0]  w_selWdata;

    // Pick the winner while idle: SNES, then a starved MCU, then S-DD1, then MCU
    always_comb begin
        w_grantSnes = 1'b0;
        w_grantMcu  = 1'b0;
        w_grantSdd1 = 1'b0;
        if (r_state == ST_IDLE) begin
            if (r_snesPend)
                w_grantSnes = 1'b1;
            else if (r_mcuPend && (r_streak == STREAK_MAX))
                w_grantMcu = 1'b1;
            else if (r_sdd1Pend)
                w_grantSdd1 = 1'b1;
            else if (r_mcuPend)
                w_grantMcu = 1'b1;
        end
    end

    assign w_anyGrant = w_grantSnes | w_grantMcu | w_grantSdd1;

    // Route the winning requester's latched address/direction/data to the bus
    always_comb begin
        w_selOwner = OWN_MCU;
        w_selWe    = r_mcuWe;
        w_selAddr  = r_mcuAddr;
        w_selWdata = r_mcuWdata;
        if (w_grantSnes) begin
            w_selOwner = OWN_SNES;
            w_selWe    = r_snesWe;
            w_selAddr  = r_snesAddr;
            w_selWdata = r_snesWdata;
        end else if (w_grantSdd1) begin
            w_selOwner = OWN_SDD1;
            w_selWe    = 1'b0;
            w_selAddr  = r_sdd1Addr;
            w_selWdata = 8'h00;
        end
    end

    // SNES request capture; a pulse while already pending is dropped
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_snesPend  <= 1'b0;
            r_snesWe    <= 1'b0;
            r_snesAddr  <= '0;
            r_snesWdata <= '0;
        end else if (w_grantSnes) begin
            r_snesPend <= 1'b0;
        end else if (snes_req && !r_snesPend) begin
            r_snesPend  <= 1'b1;
            r_snesWe    <= snes_we;
            r_snesAddr  <= snes_addr;
            r_snesWdata <= snes_wdata;
        end
    end

    // MCU request capture; a pulse while already pending is dropped
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_mcuPend  <= 1'b0;
            r_mcuWe    <= 1'b0;
            r_mcuAddr  <= '0;
            r_mcuWdata <= '0;
        end else if (w_grantMcu) begin
            r_mcuPend <= 1'b0;
        end else if (mcu_req && !r_mcuPend) begin
            r_mcuPend  <= 1'b1;
            r_mcuWe    <= mcu_we;
            r_mcuAddr  <= mcu_addr;
            r_mcuWdata <= mcu_wdata;
        end
    end

    // S-DD1 read request capture; a pulse while already pending is dropped
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sdd1Pend <= 1'b0;
            r_sdd1Addr <= '0;
        end else if (w_grantSdd1) begin
            r_sdd1Pend <= 1'b0;
        end else if (sdd1_req && !r_sdd1Pend) begin
            r_sdd1Pend <= 1'b1;
            r_sdd1Addr <= sdd1_addr;
        end
    end

    // Count S-DD1 wins that happened while the MCU was kept waiting
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            r_streak <= '0;
        else if (!r_mcuPend || w_grantMcu)
            r_streak <= '0;
        else if (w_grantSdd1 && (r_streak != STREAK_MAX))
            r_streak <= r_streak + 4'd1;
    end

    // Access sequencer: drives the PSRAM strobes and returns data/acks
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_SNES;
            r_cnt       <= '0;
            r_romAddr   <= '0;
            r_romDqO    <= '0;
            r_romDqOe   <= 1'b0;
            r_romOeN    <= 1'b1;
            r_romWeN    <= 1'b1;
            r_snesAck   <= 1'b0;
            r_mcuAck    <= 1'b0;
            r_sdd1Ack   <= 1'b0;
            r_snesRdata <= '0;
            r_mcuRdata  <= '0;
            r_sdd1Rdata <= '0;
        end else begin
            r_snesAck <= 1'b0;
            r_mcuAck  <= 1'b0;
            r_sdd1Ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_anyGrant) begin
                        r_owner   <= w_selOwner;
                        r_romAddr <= w_selAddr;
                        r_cnt     <= 8'd1;
                        if (w_selWe) begin
                            r_romDqO  <= w_selWdata;
                            r_romDqOe <= 1'b1;
                            r_romWeN  <= 1'b0;
                            r_state   <= ST_WR;
                        end else begin
                            r_romOeN <= 1'b0;
                            r_state  <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (r_cnt == RD_LAST) begin
                        r_romOeN <= 1'b1;
                        r_state  <= ST_IDLE;
                        case (r_owner)
                            OWN_SNES: begin
                                r_snesRdata <= ROM_DQ_I;
                                r_snesAck   <= 1'b1;
                            end
                            OWN_MCU: begin
                                r_mcuRdata <= ROM_DQ_I;
                                r_mcuAck   <= 1'b1;
                            end
                            default: begin
                                r_sdd1Rdata <= ROM_DQ_I;
                                r_sdd1Ack   <= 1'b1;
                            end
                        endcase
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_WR: begin
                    if (r_cnt == WR_LAST) begin
                        r_romWeN <= 1'b1;
                        r_state  <= ST_WR_HOLD;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_WR_HOLD: begin
                    r_romDqOe <= 1'b0;
                    r_state   <= ST_IDLE;
                    if (r_owner == OWN_SNES)
                        r_snesAck <= 1'b1;
                    else
                        r_mcuAck <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ROM_ADDR   = r_romAddr;
    assign ROM_DQ_O   = r_romDqO;
    assign ROM_DQ_OE  = r_romDqOe;
    assign ROM_OE_N   = r_romOeN;
    assign ROM_WE_N   = r_romWeN;
    assign snes_ack   = r_snesAck;
    assign mcu_ack    = r_mcuAck;
    assign sdd1_ack   = r_sdd1Ack;
    assign snes_rdata = r_snesRdata;
    assign mcu_rdata  = r_mcuRdata;
    assign sdd1_rdata = r_sdd1Rdata;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_rom_bus_arbiter.sv
// Testbench for rom_bus_arbiter: directed requests push expected acks into a
// scoreboard queue; a monitor pops an entry on every ack and checks the
// acking port, read data, ack cycle and the strobe widths of that access.
module tb_rom_bus_arbiter;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        snes_req = 1'b0, snes_we = 1'b0;
    logic [23:0] snes_addr = '0;
    logic [7:0]  snes_wdata = '0;
    logic [7:0]  snes_rdata;
    logic        snes_ack;
    logic        mcu_req = 1'b0, mcu_we = 1'b0;
    logic [23:0] mcu_addr = '0;
    logic [7:0]  mcu_wdata = '0;
    logic [7:0]  mcu_rdata;
    logic        mcu_ack;
    logic        sdd1_req = 1'b0;
    logic [23:0] sdd1_addr = '0;
    logic [7:0]  sdd1_rdata;
    logic        sdd1_ack;
    logic [23:0] ROM_ADDR;
    logic [7:0]  ROM_DQ_I = 8'hFF;
    logic [7:0]  ROM_DQ_O;
    logic        ROM_DQ_OE, ROM_OE_N, ROM_WE_N, busy;

    localparam logic [1:0] P_SNES = 2'd0;
    localparam logic [1:0] P_MCU  = 2'd1;
    localparam logic [1:0] P_SDD1 = 2'd2;

    typedef struct packed {
        logic [1:0] port;
        logic       isWr;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t        expQ[$];
    logic [7:0]  mem [logic [23:0]];
    int          cyc = 0;
    int          vecCount = 0;
    int          missCount = 0;
    int          oeCnt = 0, weCnt = 0, dqCnt = 0;
    logic        overlapSeen = 1'b0;
    int          r;

    rom_bus_arbiter dut (
        .CLK(CLK), .RST_N(RST_N),
        .snes_req(snes_req), .snes_we(snes_we), .snes_addr(snes_addr),
        .snes_wdata(snes_wdata), .snes_rdata(snes_rdata), .snes_ack(snes_ack),
        .mcu_req(mcu_req), .mcu_we(mcu_we), .mcu_addr(mcu_addr),
        .mcu_wdata(mcu_wdata), .mcu_rdata(mcu_rdata), .mcu_ack(mcu_ack),
        .sdd1_req(sdd1_req), .sdd1_addr(sdd1_addr),
        .sdd1_rdata(sdd1_rdata), .sdd1_ack(sdd1_ack),
        .ROM_ADDR(ROM_ADDR), .ROM_DQ_I(ROM_DQ_I), .ROM_DQ_O(ROM_DQ_O),
        .ROM_DQ_OE(ROM_DQ_OE), .ROM_OE_N(ROM_OE_N), .ROM_WE_N(ROM_WE_N),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Edge counter: at the negedge after rising edge N it reads N
    always @(posedge CLK) cyc <= cyc + 1;

    // PSRAM model: read data presented while output enable is low
    always @(negedge CLK) begin
        if (!ROM_OE_N && mem.exists(ROM_ADDR))
            ROM_DQ_I = mem[ROM_ADDR];
        else
            ROM_DQ_I = 8'hFF;
    end

    // PSRAM model: a write lands when the write strobe ends normally
    always @(posedge ROM_WE_N) begin
        if (RST_N === 1'b1)
            mem[ROM_ADDR] = ROM_DQ_O;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops one expectation per ack
    always @(negedge CLK) begin : monitorBlk
        logic [1:0] port;
        logic [7:0] rd;
        exp_t       e;
        int         nAck;
        if (!RST_N) begin
            oeCnt = 0; weCnt = 0; dqCnt = 0; overlapSeen = 1'b0;
        end else begin
            if (!ROM_OE_N) oeCnt++;
            if (!ROM_WE_N) weCnt++;
            if (ROM_DQ_OE) dqCnt++;
            if (!ROM_OE_N && ROM_DQ_OE) overlapSeen = 1'b1;
            nAck = int'(snes_ack) + int'(mcu_ack) + int'(sdd1_ack);
            if (nAck > 1) begin
                checkOutput("ack_onehot", nAck, 1);
            end else if (nAck == 1) begin
                port = snes_ack ? P_SNES : (mcu_ack ? P_MCU : P_SDD1);
                rd   = snes_ack ? snes_rdata : (mcu_ack ? mcu_rdata : sdd1_rdata);
                if (expQ.size() == 0) begin
                    vecCount++;
                    missCount++;
                    $display("[TB] FAIL unexpected_ack: port %0d acked at cycle %0d, none required", port, cyc);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("ack_port", port, e.port);
                    checkOutput("ack_cycle", cyc, e.cyc);
                    checkOutput("oe_dqoe_overlap", overlapSeen, 1'b0);
                    if (e.isWr) begin
                        checkOutput("we_low_clks", weCnt, 6);
                        checkOutput("dq_oe_clks", dqCnt, 7);
                        checkOutput("oe_low_clks_wr", oeCnt, 0);
                    end else begin
                        checkOutput("rdata", rd, e.data);
                        checkOutput("oe_low_clks", oeCnt, 5);
                        checkOutput("we_low_clks_rd", weCnt, 0);
                        checkOutput("dq_oe_clks_rd", dqCnt, 0);
                    end
                end
                oeCnt = 0; weCnt = 0; dqCnt = 0; overlapSeen = 1'b0;
            end
        end
    end

    // One clock: requests armed before the call are sampled on its rising edge
    task automatic applyStimulus();
        @(negedge CLK);
        snes_req = 1'b0;
        mcu_req  = 1'b0;
        sdd1_req = 1'b0;
    endtask

    task automatic armSnes(input logic we, input logic [23:0] addr, input logic [7:0] wd);
        snes_req = 1'b1; snes_we = we; snes_addr = addr; snes_wdata = wd;
    endtask

    task automatic armMcu(input logic we, input logic [23:0] addr, input logic [7:0] wd);
        mcu_req = 1'b1; mcu_we = we; mcu_addr = addr; mcu_wdata = wd;
    endtask

    task automatic armSdd1(input logic [23:0] addr);
        sdd1_req = 1'b1; sdd1_addr = addr;
    endtask

    task automatic pushExp(input logic [1:0] port, input logic isWr, input logic [7:0] data, input int c);
        exp_t e;
        e.port = port; e.isWr = isWr; e.data = data; e.cyc = c;
        expQ.push_back(e);
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (expQ.size() != 0 && n < budget) begin
            applyStimulus();
            n++;
        end
        if (expQ.size() != 0) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL drain_timeout: %0d acks outstanding after %0d clocks", expQ.size(), budget);
            expQ.delete();
        end
        repeat (2) applyStimulus();
    endtask

    initial begin
        mem[24'h123456] = 8'hA5;
        mem[24'h200000] = 8'h77;
        mem[24'h0000AA] = 8'h11;
        mem[24'h0000BB] = 8'h22;
        for (int j = 0; j < 5; j++) mem[24'h400000 + 24'(j)] = 8'h50 + 8'(j);

        // Reset state
        repeat (2) @(negedge CLK);
        checkOutput("reset_oe_n", ROM_OE_N, 1'b1);
        checkOutput("reset_we_n", ROM_WE_N, 1'b1);
        checkOutput("reset_dq_oe", ROM_DQ_OE, 1'b0);
        checkOutput("reset_addr", ROM_ADDR, 24'h0);
        checkOutput("reset_dq_o", ROM_DQ_O, 8'h0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_acks", {snes_ack, mcu_ack, sdd1_ack}, 3'b000);
        checkOutput("reset_rdata", {snes_rdata, mcu_rdata, sdd1_rdata}, 24'h0);
        RST_N = 1'b1;
        repeat (2) applyStimulus();

        // SNES read: grant next edge, ack five edges later
        armSnes(1'b0, 24'h123456, 8'h00);
        applyStimulus(); r = cyc;
        pushExp(P_SNES, 1'b0, 8'hA5, r + 6);
        applyStimulus();
        checkOutput("busy_during_read", busy, 1'b1);
        waitDrain(20);
        checkOutput("busy_after_read", busy, 1'b0);

        // MCU write then read-back
        armMcu(1'b1, 24'h00E000, 8'h3C);
        applyStimulus(); r = cyc;
        pushExp(P_MCU, 1'b1, 8'h00, r + 8);
        waitDrain(20);
        armMcu(1'b0, 24'h00E000, 8'h00);
        applyStimulus(); r = cyc;
        pushExp(P_MCU, 1'b0, 8'h3C, r + 6);
        waitDrain(20);

        // All three on one edge: SNES, then S-DD1, then MCU
        armSnes(1'b0, 24'h200000, 8'h00);
        armMcu(1'b0, 24'h0000AA, 8'h00);
        armSdd1(24'h400000);
        applyStimulus(); r = cyc;
        pushExp(P_SNES, 1'b0, 8'h77, r + 6);
        pushExp(P_SDD1, 1'b0, 8'h50, r + 12);
        pushExp(P_MCU,  1'b0, 8'h11, r + 18);
        waitDrain(40);

        // Starvation: S-DD1 re-requests on each ack; MCU forced after 4 S-DD1 grants.
        // A second MCU pulse while pending (addr 0000BB) must be ignored.
        armMcu(1'b0, 24'h0000AA, 8'h00);
        armSdd1(24'h400000);
        applyStimulus(); r = cyc;
        pushExp(P_SDD1, 1'b0, 8'h50, r + 6);
        pushExp(P_SDD1, 1'b0, 8'h51, r + 12);
        pushExp(P_SDD1, 1'b0, 8'h52, r + 18);
        pushExp(P_SDD1, 1'b0, 8'h53, r + 24);
        pushExp(P_MCU,  1'b0, 8'h11, r + 30);
        pushExp(P_SDD1, 1'b0, 8'h54, r + 36);
        for (int k = 1; k <= 36; k++) begin
            if (k == 3) armMcu(1'b0, 24'h0000BB, 8'h00);
            if (k == 6 || k == 12 || k == 18 || k == 24)
                armSdd1(24'h400000 + 24'(k / 6));
            applyStimulus();
        end
        waitDrain(20);

        // SNES request during an MCU write: granted the edge after mcu_ack
        armMcu(1'b1, 24'h00E001, 8'h5A);
        applyStimulus(); r = cyc;
        pushExp(P_MCU,  1'b1, 8'h00, r + 8);
        pushExp(P_SNES, 1'b0, 8'hA5, r + 14);
        for (int k = 1; k <= 14; k++) begin
            if (k == 3) armSnes(1'b0, 24'h123456, 8'h00);
            applyStimulus();
        end
        waitDrain(20);
        armSdd1(24'h00E001);
        applyStimulus(); r = cyc;
        pushExp(P_SDD1, 1'b0, 8'h5A, r + 6);
        waitDrain(20);

        // Reset in the middle of a write aborts it with no ack
        armMcu(1'b1, 24'h00E002, 8'h99);
        applyStimulus();
        repeat (3) applyStimulus();
        checkOutput("we_low_before_reset", ROM_WE_N, 1'b0);
        RST_N = 1'b0;
        #1;
        checkOutput("abort_we_n", ROM_WE_N, 1'b1);
        checkOutput("abort_dq_oe", ROM_DQ_OE, 1'b0);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_addr", ROM_ADDR, 24'h0);
        checkOutput("abort_rdata", {snes_rdata, mcu_rdata, sdd1_rdata}, 24'h0);
        repeat (2) applyStimulus();
        RST_N = 1'b1;
        repeat (10) applyStimulus();
        armSnes(1'b0, 24'h123456, 8'h00);
        applyStimulus(); r = cyc;
        pushExp(P_SNES, 1'b0, 8'hA5, r + 6);
        waitDrain(20);
        armSdd1(24'h00E002);
        applyStimulus(); r = cyc;
        pushExp(P_SDD1, 1'b0, 8'hFF, r + 6);
        waitDrain(20);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
